// File: rtl/mux_n_1_reg.sv
// Registered N:1 multiplexer with fixed-select or round-robin arbitration and a one-deep output register.
// Optional build macro MUX_N_1_REG_PARITY_EN adds the Y_par output (even parity of the held word).
module mux_n_1_reg #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    I,
    input  logic [N-1:0]      req,
    input  logic [SW-1:0]     sel,
    input  logic              mode,
    input  logic              Y_ready,
    output logic [W-1:0]      Y,
    output logic              Y_valid,
    output logic [SW-1:0]     Y_ch,
    output logic [N-1:0]      gnt
`ifdef MUX_N_1_REG_PARITY_EN
    ,
    output logic              Y_par
`endif
);

    // Channel index visited at scan step i after pointer p, wrapping modulo N.
    function automatic logic [SW-1:0] scan_idx(input logic [SW-1:0] p, input int i);
        return SW'((int'(p) + i) % N);
    endfunction

    // Request bit of channel k; indices at or above N read as no request.
    function automatic logic req_at(input logic [N-1:0] r, input logic [SW-1:0] k);
        logic b;
        b = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (k == SW'(j)) begin
                b = r[j];
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

    // Data word of channel k from the flattened bus.
    function automatic logic [W-1:0] chan_data(input logic [N*W-1:0] bus, input logic [SW-1:0] k);
        logic [W-1:0] d;
        d = '0;
        for (int j = 0; j < N; j++) begin
            if (k == SW'(j)) begin
                d = bus[j*W +: W];
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    // One-hot vector naming channel k.
    function automatic logic [N-1:0] onehot(input logic [SW-1:0] k);
        logic [N-1:0] oh;
        oh = '0;
        for (int j = 0; j < N; j++) begin
            oh[j] = (k == SW'(j));
        end
        return oh;
    endfunction

`ifdef MUX_N_1_REG_PARITY_EN
    function automatic logic parity(input logic [W-1:0] d);
        return ^d;
    endfunction
`endif

    logic [W-1:0]  y_q,     y_d;
    logic          valid_q, valid_d;
    logic [SW-1:0] ch_q,    ch_d;
    logic [N-1:0]  gnt_q,   gnt_d;
    logic [SW-1:0] ptr_q,   ptr_d;
`ifdef MUX_N_1_REG_PARITY_EN
    logic          par_q,   par_d;
`endif

    logic          load_s;
    logic          rr_hit_s;
    logic [SW-1:0] rr_win_s;
    logic          hit_s;
    logic [SW-1:0] win_s;

    // Round-robin winner: scan downward so the earliest position after ptr is written last.
    always_comb begin
        rr_hit_s = 1'b0;
        rr_win_s = ptr_q;
        for (int i = N; i >= 1; i--) begin
            if (req_at(req, scan_idx(ptr_q, i))) begin
                rr_hit_s = 1'b1;
                rr_win_s = scan_idx(ptr_q, i);
            end else begin
                rr_hit_s = rr_hit_s;
                rr_win_s = rr_win_s;
            end
        end
    end

    // Mode select, load decision and next state of the output register.
    always_comb begin
        load_s  = !valid_q || Y_ready;
        y_d     = y_q;
        valid_d = valid_q;
        ch_d    = ch_q;
        gnt_d   = '0;
        ptr_d   = ptr_q;
`ifdef MUX_N_1_REG_PARITY_EN
        par_d   = par_q;
`endif
        if (mode) begin
            hit_s = rr_hit_s;
            win_s = rr_win_s;
        end else begin
            hit_s = (int'(sel) < N) && req_at(req, sel);
            win_s = sel;
        end

        if (load_s) begin
            if (hit_s) begin
                y_d     = chan_data(I, win_s);
                valid_d = 1'b1;
                ch_d    = win_s;
                gnt_d   = onehot(win_s);
`ifdef MUX_N_1_REG_PARITY_EN
                par_d   = parity(chan_data(I, win_s));
`endif
                // Fixed-mode captures leave the pointer untouched so RR resumes where it left off.
                if (mode) begin
                    ptr_d = win_s;
                end else begin
                    ptr_d = ptr_q;
                end
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers with synchronous reset; ptr starts at N-1 so the first scan begins at channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            gnt_q   <= '0;
            ptr_q   <= SW'(N - 1);
`ifdef MUX_N_1_REG_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
`ifdef MUX_N_1_REG_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign Y       = y_q;
    assign Y_valid = valid_q;
    assign Y_ch    = ch_q;
    assign gnt     = gnt_q;
`ifdef MUX_N_1_REG_PARITY_EN
    assign Y_par   = par_q;
`endif

endmodule
